// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//
// Branch target buffer with per-entry saturating direction counters and a
// saturating misprediction counter.
//
// The lookup path is combinational. The table is direct-mapped and is
// indexed by PC bits [IDX+1:2]. The tag is the PC bits above the index.
// Resolved branches coming back from ID update the table at the next rising
// edge. A taken branch that misses allocates an entry. A not-taken branch
// that misses is dropped.
//
// Parameters:
//   ENTRIES   - table depth, power of two, 4..256
//   PC_WIDTH  - PC and target width
//   CTR_WIDTH - direction counter width, 1..4
//
// Ports:
//   clk_i          - clock, all state changes on the rising edge
//   rst_i          - synchronous active-high reset
//   pc_i           - fetch PC to look up
//   hit_o          - indexed entry is valid and its tag matches
//   pred_taken_o   - hit and counter MSB set
//   pred_target_o  - stored target on a hit, zero otherwise
//   upd_valid_i    - resolved-branch strobe
//   upd_pc_i       - resolved branch PC
//   upd_target_i   - resolved branch target
//   upd_taken_i    - actual branch outcome
//   upd_mispred_i  - the earlier prediction was wrong
//   mispred_cnt_o  - saturating 16-bit misprediction count
//
// Configuration macro:
//   BPU_BYPASS_EN  - when defined, a lookup that matches a same-cycle
//                    writing update sees the post-update entry state.

module branch_predict_unit #(
  parameter int ENTRIES   = 16,
  parameter int PC_WIDTH  = 32,
  parameter int CTR_WIDTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                hit_o,
  output logic                pred_taken_o,
  output logic [PC_WIDTH-1:0] pred_target_o,
  input  logic                upd_valid_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i,
  input  logic [PC_WIDTH-1:0] upd_target_i,
  input  logic                upd_taken_i,
  input  logic                upd_mispred_i,
  output logic [15:0]         mispred_cnt_o
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK_NT = CTR_WEAK_T - 1'b1;

  logic                 valid_q  [ENTRIES];
  logic                 valid_d  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [TAG_W-1:0]     tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0]  target_q [ENTRIES];
  logic [PC_WIDTH-1:0]  target_d [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_q    [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_d    [ENTRIES];
  logic [15:0]          mispredCnt_q;
  logic [15:0]          mispredCnt_d;

  logic [IDX-1:0]       updIdx;
  logic [TAG_W-1:0]     updTag;
  logic                 updHit;
  logic                 updWrite;
  logic [CTR_WIDTH-1:0] updCtrNew;
  logic [PC_WIDTH-1:0]  updTargetNew;

  logic [IDX-1:0]       lkIdx;
  logic [TAG_W-1:0]     lkTag;
  logic                 lkHit;
  logic [CTR_WIDTH-1:0] lkCtr;
  logic [PC_WIDTH-1:0]  lkTarget;

  logic [3:0]           unusedPcBits;

  assign updIdx = upd_pc_i[IDX+1:2];
  assign updTag = upd_pc_i[PC_WIDTH-1:IDX+2];
  assign lkIdx  = pc_i[IDX+1:2];
  assign lkTag  = pc_i[PC_WIDTH-1:IDX+2];

  // The low two PC bits are always zero for aligned instructions.
  // They take no part in indexing or tagging.
  assign unusedPcBits = {pc_i[1:0], upd_pc_i[1:0]};

  // Work out the new contents of the entry an update targets.
  // On a hit the counter saturates in the direction of the outcome. Only
  // taken branches refresh the target, because a not-taken branch resolves
  // to its fall-through address and that address is not a useful target.
  // On a miss the entry is allocated as weakly taken. updWrite is only
  // raised when the update touches the table at all.
  always_comb begin
    updHit       = valid_q[updIdx] && (tag_q[updIdx] == updTag);
    updWrite     = upd_valid_i && (updHit || upd_taken_i);
    updCtrNew    = ctr_q[updIdx];
    updTargetNew = target_q[updIdx];
    if (updHit) begin
      if (upd_taken_i) begin
        updTargetNew = upd_target_i;
        if (ctr_q[updIdx] != CTR_MAX) begin
          updCtrNew = ctr_q[updIdx] + 1'b1;
        end
      end else if (ctr_q[updIdx] != '0) begin
        updCtrNew = ctr_q[updIdx] - 1'b1;
      end
    end else begin
      updCtrNew    = CTR_WEAK_T;
      updTargetNew = upd_target_i;
    end
  end

  // Next-state computation for the table and the misprediction counter.
  // The misprediction counter sticks at all-ones instead of wrapping.
  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    ctr_d        = ctr_q;
    mispredCnt_d = mispredCnt_q;
    if (updWrite) begin
      valid_d[updIdx]  = 1'b1;
      tag_d[updIdx]    = updTag;
      target_d[updIdx] = updTargetNew;
      ctr_d[updIdx]    = updCtrNew;
    end
    if (upd_valid_i && upd_mispred_i && (mispredCnt_q != 16'hFFFF)) begin
      mispredCnt_d = mispredCnt_q + 16'd1;
    end
  end

  // State registers.
  // Reset wins over any update in the same cycle, so that update is lost.
  // Counters come out of reset weakly not-taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
      mispredCnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      mispredCnt_q <= mispredCnt_d;
    end
  end

  // Combinational lookup.
  // In bypass builds, a matching same-cycle writing update forwards the
  // entry contents it is about to write. A reset in the same cycle
  // cancels that update, so reset blocks the forward as well.
  always_comb begin
    lkHit    = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
    lkCtr    = ctr_q[lkIdx];
    lkTarget = target_q[lkIdx];
`ifdef BPU_BYPASS_EN
    if (updWrite && !rst_i && (updIdx == lkIdx) && (updTag == lkTag)) begin
      lkHit    = 1'b1;
      lkCtr    = updCtrNew;
      lkTarget = updTargetNew;
    end
`endif
  end

  assign hit_o         = lkHit;
  assign pred_taken_o  = lkHit & lkCtr[CTR_WIDTH-1];
  assign pred_target_o = lkHit ? lkTarget : '0;
  assign mispred_cnt_o = mispredCnt_q;

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, giving the table depth; legal values are powers of two from 4 to 256.
REQ-002 The block SHALL have parameter PC_WIDTH, default 32, giving the PC and target width.
REQ-003 The block SHALL have parameter CTR_WIDTH, default 2, giving the width of each saturating counter; legal values are 1 to 4.
REQ-004 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit, the reset; synchronous, active-high.
REQ-006 The block SHALL have port pc_i, input, PC_WIDTH bits, the IF-stage fetch PC used for lookup.
REQ-007 The block SHALL have port hit_o, output, 1 bit; high when the indexed entry is valid and its tag matches.
REQ-008 The block SHALL have port pred_taken_o, output, 1 bit; high when hit_o is high and the counter MSB is 1.
REQ-009 The block SHALL have port pred_target_o, output, PC_WIDTH bits, the stored target; it is 0 when hit_o is low.
REQ-010 The block SHALL have port upd_valid_i, input, 1 bit; strobes a resolved branch from ID.
REQ-011 The block SHALL have ports upd_pc_i (input, PC_WIDTH bits) and upd_target_i (input, PC_WIDTH bits), carrying the resolved branch PC and its computed target.
REQ-012 The block SHALL have ports upd_taken_i (input, 1 bit) and upd_mispred_i (input, 1 bit), carrying the actual outcome and whether the prediction was wrong.
REQ-013 The block SHALL have port mispred_cnt_o, output, 16 bits, a registered saturating count of mispredictions.

Function
REQ-014 The lookup path SHALL be combinational with zero cycle latency.
- index = pc_i[IDX+1:2], where IDX = log2(ENTRIES).
- tag = pc_i[PC_WIDTH-1:IDX+2].
REQ-015 Each entry SHALL hold: valid bit, tag, target, CTR_WIDTH-bit counter.
REQ-016 Update hit (upd_valid_i high, entry valid, tag match):
- counter increments, saturating at all-ones, when upd_taken_i=1;
- counter decrements, saturating at 0, when upd_taken_i=0;
- target overwritten with upd_target_i only when upd_taken_i=1.
REQ-017 Update miss with upd_taken_i=1 SHALL allocate the entry:
- valid=1, tag written, target=upd_target_i;
- counter = weakly taken (MSB=1, other bits 0);
- any previous occupant is overwritten.
REQ-018 Update miss with upd_taken_i=0 SHALL leave the table unchanged.
REQ-019 Update effects SHALL be visible on the lookup path from the cycle after the clock edge that samples upd_valid_i.
REQ-020 mispred_cnt_o SHALL increment by 1 on each edge with upd_valid_i=1 and upd_mispred_i=1, and hold at 16'hFFFF with no wrap.
REQ-021 upd_mispred_i and upd_taken_i SHALL be ignored when upd_valid_i=0.
REQ-022 The block SHALL never stall, and SHALL accept one update per cycle.

Reset
REQ-023 While rst_i=1 at a rising edge, all valid bits, targets and mispred_cnt_o SHALL clear to 0, and all counters SHALL set to weakly not-taken (MSB=0, other bits 1; for CTR_WIDTH=1 the value is 0).
REQ-024 Reset SHALL take precedence over a simultaneous update, and that update SHALL be discarded.
REQ-025 In the cycle after reset, hit_o=0, pred_taken_o=0 and pred_target_o=0 for every pc_i.

Configuration
REQ-026 With macro BPU_BYPASS_EN defined, a lookup whose index and tag equal those of a same-cycle valid update SHALL return the post-update entry state combinationally: hit, counter MSB and target.
REQ-027 Without BPU_BYPASS_EN, a same-cycle lookup SHALL return the pre-update state; REQ-019 then governs visibility.

Verification (ENTRIES=16, CTR_WIDTH=2)
REQ-028 Scenario: reset, then lookup pc_i=0x40 -> hit_o=0, pred_taken_o=0, pred_target_o=0.
REQ-029 Scenario: update pc=0x40, taken=1, target=0x100; next cycle lookup 0x40 -> hit_o=1, pred_taken_o=1, pred_target_o=0x100.
REQ-030 Scenario: from REQ-029 state, two not-taken updates to 0x40 -> counter=00, pred_taken_o=0, hit_o=1; then three taken updates -> counter saturates at 11.
REQ-031 Scenario: allocate 0x40, then taken update pc=0x440 (same index, different tag) with target 0x200 -> lookup 0x40 gives hit_o=0, lookup 0x440 gives target 0x200.
REQ-032 Scenario: 65537 consecutive updates with upd_mispred_i=1 -> mispred_cnt_o=0xFFFF; assert rst_i together with an update -> table empty and count 0 next cycle.
REQ-033 Scenario: same-cycle allocate and lookup of 0x80 -> hit_o=1 with BPU_BYPASS_EN defined, hit_o=0 without it.
